sensor_rst_lock_ctrl: RTL and testbench
=======================================

// Module: sensor_rst_lock_ctrl
// PURPOSE
//  Parametrised successor to the fixed 32-bit reset/lock PIO exports. Avalon-MM CSR slave that drives
//  NUM_CH per-channel sensor resets (TDC, ORCA, theta/phi clock domains, ...), both as software-held
//  levels and as timed pulses. Synchronises the per-channel PLL lock inputs, latches loss-of-lock
//  events (sticky) and raises an interrupt. Sits between the HPS lightweight bridge and the fabric.
// PARAMETERS
//  NUM_CH        4            channels, 1..32; CSR bits [31:NUM_CH] read 0, writes ignored
//  PULSE_W       16           width of pulse-length register and per-channel down-counter
//  PULSE_DEFAULT 16'd64       PULSE_LEN reset value, in clk_clk cycles
//  HOLD_INIT     {NUM_CH{1'b1}} CTRL reset value (1 = channel held in reset after reset_reset)
//  SYNC_STAGES   2            lock-input synchroniser depth, >=2
// PORTS
//  clk_clk          in   1          single clock for everything
//  reset_reset      in   1          asynchronous, active-high reset
//  avs_address      in   3          word address
//  avs_read         in   1          read strobe
//  avs_write        in   1          write strobe
//  avs_writedata    in   32         write data
//  avs_readdata     out  32         read data, valid 1 cycle after avs_read
//  lock_in          in   NUM_CH     async PLL lock per channel
//  ch_reset_out     out  NUM_CH     active-high reset per channel, registered
//  irq              out  1          level interrupt, registered
// BEHAVIOUR
//  CSR map (word addr): 0 CTRL RW hold bits | 1 PULSE W: 1=trigger, R: busy bits | 2 PULSE_LEN RW
//   [PULSE_W-1:0] | 3 LOCK RO synced lock | 4 LOST sticky, W1C | 5 IRQ_EN RW | 6,7 read 0.
//  Read latency fixed 1 cycle, no waitrequest; avs_readdata = 0 in cycles without a read the cycle before.
//  Reset values: CTRL=HOLD_INIT, PULSE_LEN=PULSE_DEFAULT, LOST=0, IRQ_EN=0, busy=0, sync chain=0,
//   ch_reset_out=HOLD_INIT, irq=0, avs_readdata=0. Reset mid-pulse aborts the pulse (busy=0).
//  Per-channel pulse FSM, IDLE/PULSE:
//   IDLE->PULSE on write of 1 to PULSE bit; cnt <= max(PULSE_LEN,1).
//   PULSE: cnt decrements each cycle; cnt==1 -> IDLE. Pulse lasts exactly max(PULSE_LEN,1) cycles.
//   Trigger while in PULSE is ignored (no restart, no extension). PULSE_LEN write mid-pulse
//    affects only later pulses.
//  ch_reset_out[i] <= CTRL[i] | pulse_active[i]; first asserted cycle is the cycle after the write.
//  Lock path: SYNC_STAGES flops, then one history flop; lost event = history 1 & synced 0.
//   Events are suppressed while ch_reset_out[i]=1 (and for SYNC_STAGES+1 cycles after it falls).
//  LOST[i] set on event; W1C clears; same-cycle set and clear -> set wins (stays 1).
//  irq <= |(LOST & IRQ_EN), one cycle after the LOST/IRQ_EN update.
//  Simultaneous triggers on several channels are independent; all counters run in parallel.
// TESTING
//  T1 reset: assert reset_reset -> ch_reset_out=4'hF, irq=0; read CTRL=0xF, PULSE_LEN=64.
//  T2 pulse: CTRL=0, PULSE_LEN=5, write PULSE=0x2 -> ch_reset_out[1] high exactly 5 cycles; busy
//     reads 0x2 during pulse, then 0; retrigger at cycle 2 does not lengthen the pulse; PULSE_LEN=0 -> 1 cycle.
//  T3 lock loss: lock_in=0xF, then drop bit 2 -> LOST=0x4 after SYNC_STAGES+1 cycles; IRQ_EN=0x4 ->
//     irq=1; write LOST=0x4 -> irq=0 next cycle.
//  T4 masking: drop lock_in[0] while CTRL[0]=1 -> LOST stays 0; release CTRL -> no event.
//  T5 race: W1C of LOST[3] in the same cycle as new loss on ch3 -> LOST[3]=1.
//  T6 async reset mid-pulse with PULSE_LEN=100 -> busy=0, outputs return to HOLD_INIT at once.

Source files
------------

// File: rtl/sensor_rst_lock_ctrl.sv
// rtl/sensor_rst_lock_ctrl.sv - CSR-driven per-channel sensor reset levels/pulses with PLL lock-loss monitor
module sensor_rst_lock_ctrl #(
  parameter int                  NUM_CH        = 4,
  parameter int                  PULSE_W       = 16,
  parameter logic [PULSE_W-1:0]  PULSE_DEFAULT = PULSE_W'(64),
  parameter logic [NUM_CH-1:0]   HOLD_INIT     = {NUM_CH{1'b1}},
  parameter int                  SYNC_STAGES   = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  input  logic [NUM_CH-1:0] lock_in,
  output logic [NUM_CH-1:0] ch_reset_out,
  output logic              irq
);

  localparam int                 MW        = $clog2(SYNC_STAGES + 2);
  localparam logic [MW-1:0]      MASK_LOAD = MW'(SYNC_STAGES + 1);
  localparam logic [MW-1:0]      MASK_ONE  = MW'(1);
  localparam logic [PULSE_W-1:0] CNT_ONE   = PULSE_W'(1);

  typedef enum logic {S_IDLE, S_PULSE} pulse_state_t;

  logic [NUM_CH-1:0]  r_ctrl, r_lost, r_irq_en, r_hist, r_ch_reset;
  logic [PULSE_W-1:0] r_pulse_len;
  logic [NUM_CH-1:0]  r_sync [SYNC_STAGES];
  pulse_state_t       r_state [NUM_CH];
  pulse_state_t       w_state_nxt [NUM_CH];
  logic [PULSE_W-1:0] r_cnt [NUM_CH];
  logic [PULSE_W-1:0] w_cnt_nxt [NUM_CH];
  logic [MW-1:0]      r_mask [NUM_CH];
  logic               r_irq;
  logic [31:0]        r_readdata, w_rdata;

  logic               w_wr_ctrl, w_wr_pulse, w_wr_len, w_wr_lost, w_wr_irq_en;
  logic [NUM_CH-1:0]  w_wdata, w_trig, w_ctrl_nxt, w_pulse_nxt, w_busy;
  logic [NUM_CH-1:0]  w_synced, w_event, w_lost_nxt;
  logic [PULSE_W-1:0] w_len_eff;
  logic               w_unused;

  assign w_wdata     = avs_writedata[NUM_CH-1:0];
  assign w_wr_ctrl   = avs_write && (avs_address == 3'd0);
  assign w_wr_pulse  = avs_write && (avs_address == 3'd1);
  assign w_wr_len    = avs_write && (avs_address == 3'd2);
  assign w_wr_lost   = avs_write && (avs_address == 3'd4);
  assign w_wr_irq_en = avs_write && (avs_address == 3'd5);
  assign w_unused    = ^avs_writedata;

  assign w_trig     = w_wr_pulse ? w_wdata : '0;
  assign w_len_eff  = (r_pulse_len == '0) ? CNT_ONE : r_pulse_len;
  assign w_ctrl_nxt = w_wr_ctrl ? w_wdata : r_ctrl;
  assign w_synced   = r_sync[SYNC_STAGES-1];

  // Per-channel pulse FSMs; next-state is used for the output register so
  // the reset pin rises the cycle right after the triggering write.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        S_IDLE: begin
          if (w_trig[i]) begin
            w_state_nxt[i] = S_PULSE;
            w_cnt_nxt[i]   = w_len_eff;
          end
        end
        S_PULSE: begin
          if (r_cnt[i] <= CNT_ONE) begin
            w_state_nxt[i] = S_IDLE;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
          end
        end
        default: begin
          w_state_nxt[i] = S_IDLE;
          w_cnt_nxt[i]   = '0;
        end
      endcase
      w_pulse_nxt[i] = (w_state_nxt[i] == S_PULSE);
      w_busy[i]      = (r_state[i] == S_PULSE);
    end
  end

  // Lock falls are ignored while a channel is held in reset and until its
  // synchroniser has flushed values captured during the hold.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_event[i] = r_hist[i] & ~w_synced[i] & ~r_ch_reset[i] & (r_mask[i] == '0);
    end
  end

  assign w_lost_nxt = (r_lost & ~(w_wr_lost ? w_wdata : '0)) | w_event;

  always_comb begin
    w_rdata = '0;
    case (avs_address)
      3'd0:    w_rdata[NUM_CH-1:0]  = r_ctrl;
      3'd1:    w_rdata[NUM_CH-1:0]  = w_busy;
      3'd2:    w_rdata[PULSE_W-1:0] = r_pulse_len;
      3'd3:    w_rdata[NUM_CH-1:0]  = w_synced;
      3'd4:    w_rdata[NUM_CH-1:0]  = r_lost;
      3'd5:    w_rdata[NUM_CH-1:0]  = r_irq_en;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
        r_mask[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
        if (r_ch_reset[i])
          r_mask[i] <= MASK_LOAD;
        else if (r_mask[i] != '0)
          r_mask[i] <= r_mask[i] - MASK_ONE;
      end
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= lock_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_hist <= w_synced;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_ctrl      <= HOLD_INIT;
      r_pulse_len <= PULSE_DEFAULT;
      r_lost      <= '0;
      r_irq_en    <= '0;
      r_ch_reset  <= HOLD_INIT;
      r_irq       <= 1'b0;
      r_readdata  <= '0;
    end else begin
      r_ctrl     <= w_ctrl_nxt;
      r_lost     <= w_lost_nxt;
      r_ch_reset <= w_ctrl_nxt | w_pulse_nxt;
      r_irq      <= |(r_lost & r_irq_en);
      r_readdata <= avs_read ? w_rdata : '0;
      if (w_wr_len)    r_pulse_len <= avs_writedata[PULSE_W-1:0];
      if (w_wr_irq_en) r_irq_en    <= w_wdata;
    end
  end

  assign avs_readdata = r_readdata;
  assign ch_reset_out = r_ch_reset;
  assign irq          = r_irq;

endmodule

// File: tb/tb_sensor_rst_lock_ctrl.sv
// tb/tb_sensor_rst_lock_ctrl.sv - scoreboard bench for sensor_rst_lock_ctrl
module tb_sensor_rst_lock_ctrl;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [3:0]  lock_in;
  logic [3:0]  ch_reset_out;
  logic        irq;

  always #5 clk_clk = ~clk_clk;

  sensor_rst_lock_ctrl dut (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .lock_in      (lock_in),
    .ch_reset_out (ch_reset_out),
    .irq          (irq)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  rd_exp_t sb_e;
  int      n_pass  = 0;
  int      n_total = 0;
  logic    rd_d;

  always @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) rd_d <= 1'b0;
    else             rd_d <= avs_read;
  end

  // Read-data monitor: one expected word per issued read, in order
  always @(negedge clk_clk) begin
    if (rd_d) begin
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_read: got %h, expected no read data", avs_readdata);
      end else begin
        sb_e = sb_q.pop_front();
        if (avs_readdata === sb_e.exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", sb_e.name, avs_readdata, sb_e.exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk_clk);
    avs_write     = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    rd_exp_t e;
    e.name = name;
    e.exp  = exp;
    avs_address = a;
    avs_read    = 1'b1;
    sb_q.push_back(e);
    @(negedge clk_clk);
    avs_read    = 1'b0;
  endtask

  initial begin
    reset_reset   = 1'b1;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    lock_in       = 4'hF;

    // T1 reset state
    cyc(2);
    chk("t1_rst_pins", {28'd0, ch_reset_out}, 32'hF);
    chk("t1_rst_irq", {31'd0, irq}, 32'h0);
    chk("t1_rst_rdata", avs_readdata, 32'h0);
    reset_reset = 1'b0;
    cyc(3);
    csr_rd(3'd0, 32'hF, "t1_ctrl");
    csr_rd(3'd2, 32'd64, "t1_pulse_len");
    csr_rd(3'd4, 32'h0, "t1_lost");
    csr_rd(3'd5, 32'h0, "t1_irq_en");
    csr_rd(3'd1, 32'h0, "t1_busy");
    csr_rd(3'd3, 32'hF, "t1_lock");
    csr_rd(3'd7, 32'h0, "t1_addr7");
    chk("t1_idle_rdata", avs_readdata, 32'h0);

    // T2 pulses: 5-cycle pulse with retrigger ignored, zero length, multi-channel
    csr_wr(3'd0, 32'h0);
    cyc(4);
    chk("t2_pins_released", {28'd0, ch_reset_out}, 32'h0);
    csr_wr(3'd2, 32'd5);
    csr_wr(3'd1, 32'h2);
    for (int k = 0; k < 8; k++) begin
      chk("t2_pulse_pin", {28'd0, ch_reset_out}, (k < 5) ? 32'h2 : 32'h0);
      avs_write = 1'b0;
      avs_read  = 1'b0;
      if (k == 1) begin
        avs_address   = 3'd1;
        avs_writedata = 32'h2;
        avs_write     = 1'b1;
      end
      if (k == 2 || k == 6) begin
        sb_e.name = "t2_busy";
        sb_e.exp  = (k == 2) ? 32'h2 : 32'h0;
        sb_q.push_back(sb_e);
        avs_address = 3'd1;
        avs_read    = 1'b1;
      end
      @(negedge clk_clk);
    end
    avs_write = 1'b0;
    avs_read  = 1'b0;
    csr_wr(3'd2, 32'd0);
    csr_wr(3'd1, 32'h2);
    chk("t2_len0_on", {28'd0, ch_reset_out}, 32'h2);
    cyc(1);
    chk("t2_len0_off", {28'd0, ch_reset_out}, 32'h0);
    csr_wr(3'd2, 32'd3);
    csr_wr(3'd1, 32'h5);
    chk("t2_multi_first", {28'd0, ch_reset_out}, 32'h5);
    cyc(2);
    chk("t2_multi_last", {28'd0, ch_reset_out}, 32'h5);
    cyc(1);
    chk("t2_multi_off", {28'd0, ch_reset_out}, 32'h0);
    csr_rd(3'd2, 32'd3, "t2_pulse_len");

    // T3 lock loss on channel 2, interrupt enable and W1C
    lock_in = 4'hB;
    cyc(2);
    csr_rd(3'd4, 32'h0, "t3_lost_early");
    csr_rd(3'd4, 32'h4, "t3_lost");
    chk("t3_irq_masked", {31'd0, irq}, 32'h0);
    csr_wr(3'd5, 32'h4);
    chk("t3_irq_lag", {31'd0, irq}, 32'h0);
    cyc(1);
    chk("t3_irq_on", {31'd0, irq}, 32'h1);
    csr_wr(3'd4, 32'h4);
    chk("t3_irq_hold", {31'd0, irq}, 32'h1);
    cyc(1);
    chk("t3_irq_off", {31'd0, irq}, 32'h0);
    lock_in = 4'hF;
    cyc(4);
    csr_rd(3'd3, 32'hF, "t3_lock_back");

    // T4 masking during hold and just after release
    csr_wr(3'd0, 32'h1);
    cyc(2);
    lock_in = 4'hE;
    cyc(6);
    csr_rd(3'd4, 32'h0, "t4_lost_held");
    lock_in = 4'hF;
    cyc(4);
    csr_wr(3'd0, 32'h0);
    lock_in = 4'hE;
    cyc(6);
    csr_rd(3'd4, 32'h0, "t4_lost_release");
    chk("t4_irq", {31'd0, irq}, 32'h0);
    lock_in = 4'hF;
    cyc(5);

    // T5 W1C racing a new loss on channel 3
    lock_in = 4'h7;
    cyc(2);
    csr_wr(3'd4, 32'h8);
    csr_rd(3'd4, 32'h8, "t5_race");
    csr_wr(3'd5, 32'h8);
    cyc(1);
    chk("t5_irq", {31'd0, irq}, 32'h1);
    lock_in = 4'hF;
    cyc(4);

    // T6 async reset in the middle of a long pulse
    csr_wr(3'd2, 32'd100);
    csr_wr(3'd1, 32'h3);
    cyc(10);
    chk("t6_pulse_pins", {28'd0, ch_reset_out}, 32'h3);
    csr_rd(3'd1, 32'h3, "t6_busy_mid");
    #2 reset_reset = 1'b1;
    #1;
    chk("t6_async_pins", {28'd0, ch_reset_out}, 32'hF);
    chk("t6_async_irq", {31'd0, irq}, 32'h0);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    cyc(1);
    csr_rd(3'd1, 32'h0, "t6_busy_after");
    csr_rd(3'd2, 32'd64, "t6_pulse_len");
    csr_rd(3'd4, 32'h0, "t6_lost");
    csr_rd(3'd0, 32'hF, "t6_ctrl");
    chk("t6_pins_after", {28'd0, ch_reset_out}, 32'hF);

    for (int w = 0; w < 20 && sb_q.size() != 0; w++) @(negedge clk_clk);
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d outstanding reads, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
